// File: rtl/counter_pkg.sv
// Shared types and the load-clamp helper for mod_n_updown_counter.
package counter_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;

  localparam int unsigned CLAMP_W = 32;

  function automatic logic [CLAMP_W-1:0] clamp_load(input logic [CLAMP_W-1:0] value,
                                                    input logic [CLAMP_W-1:0] max);
    logic [CLAMP_W-1:0] res;
    if (value > max) begin
      res = max;
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler for mod_n_updown_counter: tick on every PRESCALE-th en cycle.
// Instantiated only when COUNTER_PRESCALE_EN is defined.
module counter_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q;
  logic [PS_W-1:0] ps_d;

  assign tick = en && (ps_q == PS_LAST);

  // Phase advance: restart wins, en=0 holds the phase.
  always_comb begin
    ps_d = ps_q;
    if (restart) begin
      ps_d = {PS_W{1'b0}};
    end else if (en) begin
      if (tick) begin
        ps_d = {PS_W{1'b0}};
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end else begin
      ps_d = ps_q;
    end
  end

  // Phase register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_q <= {PS_W{1'b0}};
    end else begin
      ps_q <= ps_d;
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with clear, clamped load, wrap/saturate mode and boundary flags.
// Optional enable prescaler under COUNTER_PRESCALE_EN.
module mod_n_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned MAX_VAL   = 2**WIDTH - 1,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned RESET_VAL = 0,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);
  localparam mode_e            MODE  = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  logic             step_s;
  dir_e             dir_s;
  logic [WIDTH-1:0] load_clamped_s;
  logic [WIDTH:0]   count_x_s, inc_x_s, dec_x_s;
  logic             hit_max_s, hit_zero_s;

`ifdef COUNTER_PRESCALE_EN
  logic restart_s;
  assign restart_s = clr | load;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .restart (restart_s),
    .tick    (step_s)
  );
`else
  assign step_s = en;
`endif

  assign dir_s          = up ? DIR_UP : DIR_DOWN;
  assign load_clamped_s = WIDTH'(clamp_load(CLAMP_W'(load_val), CLAMP_W'(MAX_VAL)));

  // The extra bit catches both the step past MAX_VAL and the borrow below zero.
  assign count_x_s  = {1'b0, count_q};
  assign inc_x_s    = count_x_s + {{WIDTH{1'b0}}, 1'b1};
  assign dec_x_s    = count_x_s - {{WIDTH{1'b0}}, 1'b1};
  assign hit_max_s  = (inc_x_s > MAX_X);
  assign hit_zero_s = dec_x_s[WIDTH];

  // Next-state: clr > load > step; boundary steps pulse wrap and set ovf.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = RST_C;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_clamped_s;
    end else if (step_s) begin
      case (dir_s)
        DIR_UP: begin
          if (hit_max_s) begin
            wrap_d = 1'b1;
            ovf_d  = 1'b1;
            case (MODE)
              MODE_SAT: count_d = count_q;
              default:  count_d = {WIDTH{1'b0}};
            endcase
          end else begin
            count_d = inc_x_s[WIDTH-1:0];
          end
        end
        DIR_DOWN: begin
          if (hit_zero_s) begin
            wrap_d = 1'b1;
            ovf_d  = 1'b1;
            case (MODE)
              MODE_SAT: count_d = count_q;
              default:  count_d = MAX_C;
            endcase
          end else begin
            count_d = dec_x_s[WIDTH-1:0];
          end
        end
        default: count_d = count_q;
      endcase
    end else begin
      count_d = count_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RST_C;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count   = count_q;
  assign wrap    = wrap_q;
  assign ovf     = ovf_q;
  assign at_max  = (count_q == MAX_C);
  assign at_zero = (count_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Scoreboard bench for mod_n_updown_counter: a wrap-mode and a saturate-mode instance
// (WIDTH=3, MAX_VAL=5) share stimulus and are checked against an independent model.
module tb_mod_n_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, clr = 1'b0, up = 1'b0, load = 1'b0;
  logic [2:0] load_val = 3'd0;

  logic [2:0] cnt_w, cnt_s;
  logic       amax_w, azero_w, wrap_w, ovf_w;
  logic       amax_s, azero_s, wrap_s, ovf_s;
  logic [6:0] obs_w, obs_s;

  assign obs_w = {cnt_w, wrap_w, ovf_w, amax_w, azero_w};
  assign obs_s = {cnt_s, wrap_s, ovf_s, amax_s, azero_s};

  int checks = 0;
  int errors = 0;

  logic [6:0] q_w[$];
  logic [6:0] q_s[$];

  int m_cnt[2];
  bit m_wrap[2];
  bit m_ovf[2];
  int m_ps;

  always #5 clk = ~clk;

  mod_n_updown_counter #(.WIDTH(3), .MAX_VAL(5), .SATURATE(0), .RESET_VAL(0), .PRESCALE(4)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .up(up), .load(load), .load_val(load_val),
    .count(cnt_w), .at_max(amax_w), .at_zero(azero_w), .wrap(wrap_w), .ovf(ovf_w));

  mod_n_updown_counter #(.WIDTH(3), .MAX_VAL(5), .SATURATE(1), .RESET_VAL(0), .PRESCALE(4)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .up(up), .load(load), .load_val(load_val),
    .count(cnt_s), .at_max(amax_s), .at_zero(azero_s), .wrap(wrap_s), .ovf(ovf_s));

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_wrap[d] = 1'b0; m_ovf[d] = 1'b0;
    end
    m_ps = 0;
  endtask

  // Advance the model by one edge using the current inputs and queue the expectations.
  task automatic model_edge();
    bit adv;
    logic [2:0] c3;
`ifdef COUNTER_PRESCALE_EN
    if (clr || load) begin adv = 1'b0; m_ps = 0; end
    else if (en) begin adv = (m_ps == 3); m_ps = adv ? 0 : m_ps + 1; end
    else adv = 1'b0;
`else
    adv = en;
`endif
    for (int d = 0; d < 2; d++) begin
      m_wrap[d] = 1'b0;
      if (clr) begin
        m_cnt[d] = 0; m_ovf[d] = 1'b0;
      end else if (load) begin
        m_cnt[d] = (int'(load_val) > 5) ? 5 : int'(load_val);
      end else if (adv) begin
        if (up) begin
          if (m_cnt[d] == 5) begin m_wrap[d] = 1'b1; m_ovf[d] = 1'b1; m_cnt[d] = (d == 1) ? 5 : 0; end
          else m_cnt[d] = m_cnt[d] + 1;
        end else begin
          if (m_cnt[d] == 0) begin m_wrap[d] = 1'b1; m_ovf[d] = 1'b1; m_cnt[d] = (d == 1) ? 0 : 5; end
          else m_cnt[d] = m_cnt[d] - 1;
        end
      end
    end
    c3 = 3'(m_cnt[0]);
    q_w.push_back({c3, m_wrap[0], m_ovf[0], m_cnt[0] == 5, m_cnt[0] == 0});
    c3 = 3'(m_cnt[1]);
    q_s.push_back({c3, m_wrap[1], m_ovf[1], m_cnt[1] == 5, m_cnt[1] == 0});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit e, input bit u, input bit l, input bit c, input logic [2:0] v);
    en = e; up = u; load = l; clr = c; load_val = v;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_w !== 7'b000_0_0_0_1) begin errors++; $display("FAIL reset wrap-dut got=%b exp=%b", obs_w, 7'b000_0_0_0_1); end
    checks++;
    if (obs_s !== 7'b000_0_0_0_1) begin errors++; $display("FAIL reset sat-dut got=%b exp=%b", obs_s, 7'b000_0_0_0_1); end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_wrap_up();
    logic [6:0] e;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 7 * 4; i++) begin
      step();
      e = q_w.pop_front(); checks++;
      if (obs_w !== e) begin errors++; $display("FAIL wrap_up[%0d] wrap-dut got=%b exp=%b", i, obs_w, e); end
      e = q_s.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL wrap_up[%0d] sat-dut got=%b exp=%b", i, obs_s, e); end
    end
  endtask

  task automatic test_saturate();
    logic [6:0] e;
    for (int i = 0; i < 1 + 8 * 4; i++) begin
      set_in(1'b1, 1'b1, 1'b0, i == 0, 3'd0);
      step();
      e = q_w.pop_front(); checks++;
      if (obs_w !== e) begin errors++; $display("FAIL saturate[%0d] wrap-dut got=%b exp=%b", i, obs_w, e); end
      e = q_s.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL saturate[%0d] sat-dut got=%b exp=%b", i, obs_s, e); end
    end
  endtask

  task automatic test_down_boundary();
    logic [6:0] e;
    for (int i = 0; i < 1 + 4; i++) begin
      set_in(1'b1, 1'b0, 1'b0, i == 0, 3'd0);
      step();
      e = q_w.pop_front(); checks++;
      if (obs_w !== e) begin errors++; $display("FAIL down_boundary[%0d] wrap-dut got=%b exp=%b", i, obs_w, e); end
      e = q_s.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL down_boundary[%0d] sat-dut got=%b exp=%b", i, obs_s, e); end
    end
  endtask

  task automatic test_load_clr();
    logic [6:0] e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_in(1'b1, 1'b1, 1'b1, 1'b0, 3'd7);
        1: set_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        2: set_in(1'b1, 1'b1, 1'b1, 1'b1, 3'd3);
        default: set_in(1'b0, 1'b1, 1'b1, 1'b0, 3'd6);
      endcase
      step();
      e = q_w.pop_front(); checks++;
      if (obs_w !== e) begin errors++; $display("FAIL load_clr[%0d] wrap-dut got=%b exp=%b", i, obs_w, e); end
      e = q_s.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL load_clr[%0d] sat-dut got=%b exp=%b", i, obs_s, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] e;
    int n = 0;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    step();
    e = q_w.pop_front(); void'(q_s.pop_front()); checks++;
    if (obs_w !== e) begin errors++; $display("FAIL async_reset_clr wrap-dut got=%b exp=%b", obs_w, e); end
    clr = 1'b0;
    do begin
      step(); n++;
      e = q_w.pop_front(); checks++;
      if (obs_w !== e) begin errors++; $display("FAIL async_reset_pre[%0d] wrap-dut got=%b exp=%b", n, obs_w, e); end
      e = q_s.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL async_reset_pre[%0d] sat-dut got=%b exp=%b", n, obs_s, e); end
    end while (m_cnt[0] != 3 && n < 40);
    checks++;
    if (n >= 40) begin errors++; $display("FAIL async_reset_reach3 steps=%0d limit=40", n); end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (obs_w !== 7'b000_0_0_0_1) begin errors++; $display("FAIL async_reset wrap-dut got=%b exp=%b", obs_w, 7'b000_0_0_0_1); end
    checks++;
    if (obs_s !== 7'b000_0_0_0_1) begin errors++; $display("FAIL async_reset sat-dut got=%b exp=%b", obs_s, 7'b000_0_0_0_1); end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      e = q_w.pop_front(); checks++;
      if (obs_w !== e) begin errors++; $display("FAIL async_reset_post[%0d] wrap-dut got=%b exp=%b", i, obs_w, e); end
      e = q_s.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL async_reset_post[%0d] sat-dut got=%b exp=%b", i, obs_s, e); end
    end
  endtask

`ifdef COUNTER_PRESCALE_EN
  task automatic test_prescale();
    logic [6:0] e;
    for (int i = 0; i < 24; i++) begin
      if (i == 0) set_in(1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
      else if (i == 6 || i == 7) set_in(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
      else if (i == 14) set_in(1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
      else set_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      step();
      e = q_w.pop_front(); checks++;
      if (obs_w !== e) begin errors++; $display("FAIL prescale[%0d] wrap-dut got=%b exp=%b", i, obs_w, e); end
      e = q_s.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL prescale[%0d] sat-dut got=%b exp=%b", i, obs_s, e); end
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [6:0] e;
    for (int i = 0; i < 80; i++) begin
      set_in($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
             $urandom_range(9, 0) == 0, $urandom_range(19, 0) == 0, 3'($urandom_range(7, 0)));
      step();
      e = q_w.pop_front(); checks++;
      if (obs_w !== e) begin errors++; $display("FAIL back_to_back[%0d] wrap-dut got=%b exp=%b", i, obs_w, e); end
      e = q_s.pop_front(); checks++;
      if (obs_s !== e) begin errors++; $display("FAIL back_to_back[%0d] sat-dut got=%b exp=%b", i, obs_s, e); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wrap_up();
    test_saturate();
    test_down_boundary();
    test_load_clr();
    test_async_reset();
`ifdef COUNTER_PRESCALE_EN
    test_prescale();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
